// File: rtl/dm_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_stage_if
// Description : M-stage request / W-stage result bundle of the data-memory
//               stage.
//               master : pipeline side, drives the M-stage fields and
//                        receives the registered W-stage fields.
//               slave  : dm_stage side.
//               M fields : PC_M, Addr_M, WData_M, Store_Op_M, Load_M,
//                          Load_extOp_M
//               W fields : RData_W, Byte_W, Load_extOp_W, AdEL_W, AdES_W
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_stage_if;
  logic [31:0] PC_M;
  logic [31:0] Addr_M;
  logic [31:0] WData_M;
  logic [1:0]  Store_Op_M;
  logic        Load_M;
  logic [1:0]  Load_extOp_M;

  logic [31:0] RData_W;
  logic [1:0]  Byte_W;
  logic [1:0]  Load_extOp_W;
  logic        AdEL_W;
  logic        AdES_W;

  modport master (
    output PC_M, Addr_M, WData_M, Store_Op_M, Load_M, Load_extOp_M,
    input  RData_W, Byte_W, Load_extOp_W, AdEL_W, AdES_W
  );

  modport slave (
    input  PC_M, Addr_M, WData_M, Store_Op_M, Load_M, Load_extOp_M,
    output RData_W, Byte_W, Load_extOp_W, AdEL_W, AdES_W
  );
endinterface
`default_nettype wire

// File: rtl/dm_stage.sv
`default_nettype none
// ============================================================================
// Module      : dm_stage
// Description : Data-memory stage. Holds the data RAM, performs sw/sh/sb
//               byte-lane writes, reads the addressed word combinationally in
//               M and registers the raw word, byte offset and load-extension
//               opcode into the M/W boundary. Flags misaligned or
//               out-of-range loads (AdEL_W) and stores (AdES_W).
// Ports       : clk   - rising-edge clock
//               reset - synchronous active-high reset
//               bus   - dm_stage_if.slave (M-stage inputs, W-stage outputs)
// Parameters  : DEPTH_WORDS - RAM depth in 32-bit words
// Revision    : 1.0 - initial release
// ============================================================================
module dm_stage #(
  parameter int DEPTH_WORDS = 3072
) (
  input  wire logic   clk,
  input  wire logic   reset,
  dm_stage_if.slave   bus
);

  localparam int          c_IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] c_BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  localparam logic [1:0] c_ST_NONE = 2'b00;
  localparam logic [1:0] c_ST_SW   = 2'b01;
  localparam logic [1:0] c_ST_SH   = 2'b10;
  localparam logic [1:0] c_ST_SB   = 2'b11;

  localparam logic [1:0] c_LD_WORD = 2'b00;
  localparam logic [1:0] c_LD_HALF = 2'b01;

  // Storage. The data array itself has no reset; a per-word valid vector is
  // cleared instead, so that reset makes every word read as zero in a single
  // cycle while the array can still map onto a plain RAM.
  logic [31:0]            r_mem [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] r_valid;

  logic [31:0] r_rdata;
  logic [1:0]  r_byte;
  logic [1:0]  r_ext;
  logic        r_adel;
  logic        r_ades;

  logic               w_in_range;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]        w_old;
  logic [3:0]         w_be;
  logic [31:0]        w_lane_data;
  logic [31:0]        w_merged;
  logic               w_ades;
  logic               w_adel;
  logic               w_we;

  // Full 32-bit compare: high address bits never alias back into the array.
  assign w_in_range = {1'b0, bus.Addr_M} < c_BYTE_LIMIT;
  assign w_idx      = bus.Addr_M[c_IDX_W+1:2];
  assign w_old      = (w_in_range && r_valid[w_idx]) ? r_mem[w_idx] : 32'h0;

  always_comb begin
    w_be = 4'b0000;
    case (bus.Store_Op_M)
      c_ST_SW: w_be = 4'b1111;
      c_ST_SH: w_be = bus.Addr_M[1] ? 4'b1100 : 4'b0011;
      c_ST_SB: w_be = 4'b0001 << bus.Addr_M[1:0];
      default: w_be = 4'b0000;
    endcase
  end

  always_comb begin
    w_lane_data = bus.WData_M;
    case (bus.Store_Op_M)
      c_ST_SH: w_lane_data = {2{bus.WData_M[15:0]}};
      c_ST_SB: w_lane_data = {4{bus.WData_M[7:0]}};
      default: w_lane_data = bus.WData_M;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_merged[8*i +: 8] = w_be[i] ? w_lane_data[8*i +: 8] : w_old[8*i +: 8];
  end

  always_comb begin
    w_ades = 1'b0;
    if (bus.Store_Op_M != c_ST_NONE) begin
      w_ades = !w_in_range
            || ((bus.Store_Op_M == c_ST_SW) && (bus.Addr_M[1:0] != 2'b00))
            || ((bus.Store_Op_M == c_ST_SH) && bus.Addr_M[0]);
    end
  end

  always_comb begin
    w_adel = 1'b0;
    if (bus.Load_M) begin
      w_adel = !w_in_range
            || ((bus.Load_extOp_M == c_LD_WORD) && (bus.Addr_M[1:0] != 2'b00))
            || ((bus.Load_extOp_M == c_LD_HALF) && bus.Addr_M[0]);
    end
  end

  assign w_we = (|w_be) && !w_ades && !reset;

  // Data array: no reset, write-only port on the clock edge.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Valid vector and M/W boundary registers. r_rdata takes w_old, so a load
  // paired with a store to the same word sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_rdata <= 32'h0;
      r_byte  <= 2'b00;
      r_ext   <= 2'b00;
      r_adel  <= 1'b0;
      r_ades  <= 1'b0;
    end else begin
      if (w_we) begin
        r_valid[w_idx] <= 1'b1;
      end
      r_rdata <= w_old;
      r_byte  <= bus.Addr_M[1:0];
      r_ext   <= bus.Load_extOp_M;
      r_adel  <= w_adel;
      r_ades  <= w_ades;
    end
  end

`ifndef SYNTHESIS
  // Write trace, one line per committed store.
  always_ff @(posedge clk) begin
    if (w_we) begin
      $display("%d@%h: *%h <= %h", $time, bus.PC_M, {bus.Addr_M[31:2], 2'b00}, w_merged);
    end
  end
`endif

  assign bus.RData_W      = r_rdata;
  assign bus.Byte_W       = r_byte;
  assign bus.Load_extOp_W = r_ext;
  assign bus.AdEL_W       = r_adel;
  assign bus.AdES_W       = r_ades;

endmodule
`default_nettype wire

// File: doc/dm_stage.md
# dm_stage

Data-memory stage of the five-stage pipeline, sitting directly upstream of `load_ext`. It holds the data RAM and performs sw/sh/sb byte-lane writes. It reads the addressed word combinationally during M. At each clock edge it registers the raw word, byte offset and load-extension opcode into the M/W boundary, and `load_ext` consumes those values in W. It also flags misaligned or out-of-range accesses for later exception handling.

## Interface
- `DEPTH_WORDS`, 3072: RAM depth in 32-bit words; the valid byte range is 0 to DEPTH_WORDS*4-1 (0x0000–0x2FFF at default).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; the only clock is `clk`.
- `PC_M`  in  32  PC of the M-stage instruction; used only for the write trace.
- `Addr_M`  in  32  byte address (ALU result).
- `WData_M`  in  32  store data (forwarded rt); sh uses bits [15:0], sb uses bits [7:0].
- `Store_Op_M`  in  2  00 none, 01 sw, 10 sh, 11 sb.
- `Load_M`  in  1  the M-stage instruction is a load.
- `Load_extOp_M`  in  2  00 word, 01 lh, 10 lb; passed through unchanged.
- `RData_W`  out  32  registered raw memory word.
- `Byte_W`  out  2  registered `Addr_M[1:0]`.
- `Load_extOp_W`  out  2  registered `Load_extOp_M`.
- `AdEL_W`  out  1  registered load address error.
- `AdES_W`  out  1  registered store address error.

## Operation
- Word index = `Addr_M[31:2]`. The address is in range when `Addr_M` < DEPTH_WORDS*4.
- Store lane enables (`be[3:0]`):
  - sw: 1111.
  - sh: 0011 when `Addr_M[1]`=0, otherwise 1100.
  - sb: one-hot bit `Addr_M[1:0]`.
  - none: 0000.
- Lane data: sh replicates `WData_M[15:0]` into both halves; sb replicates `WData_M[7:0]` into all four bytes. Each enabled byte lane is written from its matching lane of the replicated data.
- Store error (`ades`): store op ≠ 00 and any of the following:
  - sw with `Addr_M[1:0]`≠00;
  - sh with `Addr_M[0]`=1;
  - address out of range.
  When `ades` is set, no byte is written.
- Load error (`adel`): `Load_M`=1 and any of the following:
  - word load with `Addr_M[1:0]`≠00;
  - lh with `Addr_M[0]`=1;
  - address out of range.
- Read: the combinational word at the word index, or 0 when out of range.
- Write trace: every performed write prints `$display("%d@%h: *%h <= %h", $time, PC_M, {Addr_M[31:2],2'b00}, merged_word)`. `merged_word` is the complete 32-bit word after lane merge. Suppressed writes print nothing.
- Store and load both set (illegal decode): the store takes effect, and the read registers the pre-write word.

## Timing
- Reset, at a rising edge with `reset`=1:
  - every RAM word is set to 0;
  - `RData_W`, `Byte_W` and `Load_extOp_W` are set to 0;
  - `AdEL_W` and `AdES_W` are set to 0;
  - no write occurs that cycle, even with a store present.
- A store commits at the rising edge that ends its M cycle.
- M→W latency is 1 cycle. The W outputs update at every non-reset edge; this stage has no stall and no enable.
- Read-during-write to the same word in the same cycle: `RData_W` captures the OLD word. A load in the following cycle reads the new word; no forwarding is required.
- A back-to-back sb to the same word at offsets 0,1,2,3 accumulates all four bytes.
- Reset asserted between a store and a subsequent load: the RAM is cleared, and the load returns 0.
- The `Addr_M` wrap-around above 0x2FFF is not aliased; such accesses are treated as out-of-range.

## Test plan
- Reset, then sw 0x12345678 @0x0000, then lw @0x0000 next cycle. Required: `RData_W`=0x12345678, `Byte_W`=00, and one trace line showing `*00000000 <= 12345678`.
- Starting from word 0x12345678 @0x0004: sh 0xABCD @0x0006, then lh @0x0006. Required: the word becomes 0xABCD5678, `Byte_W`=10, `Load_extOp_W`=01.
- sb 0x11,0x22,0x33,0x44 to @0x8..0xB on consecutive cycles, then lw @0x8. Required: `RData_W`=0x44332211.
- sw @0x0010 and lw @0x0010 in the same cycle (old word 0xDEADBEEF, new word 0x0). Required: `RData_W`=0xDEADBEEF; a lw in the next cycle yields 0x0.
- sh @0x0003 and sw @0x3000. Required: `AdES_W`=1 in the next cycle, RAM unchanged, no trace. lw @0x0002 requires `AdEL_W`=1.
- sw 0xFFFFFFFF @0x0020, then reset for 1 cycle, then lw @0x0020. Required: `RData_W`=0, and all W outputs are 0 during the reset edge.
